// File: rtl/uart_echo_ctrl_pkg.sv
// Shared encodings for the UART echo controller: operating modes, FSM states
// and the default UART word width.
package uart_echo_ctrl_pkg;

  localparam int DBIT_DEF = 8;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_ECHO  = 2'd1,
    MODE_INC   = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage

// File: rtl/uart_echo_ctrl_hex_to_sseg.sv
// Hex digit to active-low seven-segment pattern {dp,g,f,e,d,c,b,a}.
// dp is active-high here: 1 lights the decimal point.
module hex_to_sseg (
  input  logic [3:0] hex,
  input  logic       dp,
  output logic [7:0] sseg
);

  always_comb begin
    sseg[7]   = ~dp;
    sseg[6:0] = 7'b1111111;
    case (hex)
      4'h0: sseg[6:0] = 7'b1000000;
      4'h1: sseg[6:0] = 7'b1111001;
      4'h2: sseg[6:0] = 7'b0100100;
      4'h3: sseg[6:0] = 7'b0110000;
      4'h4: sseg[6:0] = 7'b0011001;
      4'h5: sseg[6:0] = 7'b0010010;
      4'h6: sseg[6:0] = 7'b0000010;
      4'h7: sseg[6:0] = 7'b1111000;
      4'h8: sseg[6:0] = 7'b0000000;
      4'h9: sseg[6:0] = 7'b0010000;
      4'hA: sseg[6:0] = 7'b0001000;
      4'hB: sseg[6:0] = 7'b0000011;
      4'hC: sseg[6:0] = 7'b1000110;
      4'hD: sseg[6:0] = 7'b0100001;
      4'hE: sseg[6:0] = 7'b0000110;
      4'hF: sseg[6:0] = 7'b0001110;
      default: sseg[6:0] = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/uart_echo_ctrl.sv
// UART echo/test-pattern controller: echoes, increments, or generates bytes
// into the UART TX FIFO and shows last RX byte and TX count on a 4-digit display.
module uart_echo_ctrl
  import uart_echo_ctrl_pkg::*;
#(
  parameter int              DBIT         = DBIT_DEF,
  parameter logic [DBIT-1:0] CONST_VAL    = DBIT'(8'h33),
  parameter int              BURST_LEN    = 16,
  parameter int              REFRESH_BITS = 18
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            btn_tick,
  input  logic [1:0]      mode,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [DBIT-1:0] w_data,
  output logic [7:0]      led,
  output logic [3:0]      an,
  output logic [7:0]      sseg
);

  state_e                  state, state_n;
  mode_e                   mode_sel;
  logic [DBIT-1:0]         tx_reg, tx_n;
  logic [7:0]              burst_cnt, burst_n;
  logic [7:0]              led_n;
  logic [7:0]              tx_cnt;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              digit_sel;
  logic [3:0]              hex_digit;
  logic [3:0]              an_n;
  logic [7:0]              sseg_n;

  assign mode_sel = mode_e'(mode);
  assign w_data   = tx_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      tx_reg    <= '0;
      burst_cnt <= '0;
      led       <= '0;
      tx_cnt    <= '0;
    end else begin
      state     <= state_n;
      tx_reg    <= tx_n;
      burst_cnt <= burst_n;
      led       <= led_n;
      if (wr_uart) tx_cnt <= tx_cnt + 8'd1;
    end
  end

  // Strobes are suppressed while reset is high so nothing is popped or pushed
  // in the reset cycle itself. burst_cnt returns to 0 at the end of a burst,
  // so "burst_cnt > 1" alone identifies a burst still in progress.
  always_comb begin
    state_n = state;
    tx_n    = tx_reg;
    burst_n = burst_cnt;
    led_n   = led;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    if (!reset) begin
      case (state)
        ST_IDLE: begin
          case (mode_sel)
            MODE_ECHO, MODE_INC: begin
              if (!rx_empty) begin
                rd_uart = 1'b1;
                tx_n    = (mode_sel == MODE_INC) ? r_data + 1'b1 : r_data;
                led_n   = 8'(r_data);
                state_n = ST_SEND;
              end
            end
            MODE_CONST: begin
              if (btn_tick) begin
                tx_n    = CONST_VAL;
                state_n = ST_SEND;
              end
            end
            MODE_BURST: begin
              if (btn_tick) begin
                tx_n    = '0;
                burst_n = 8'(BURST_LEN);
                state_n = ST_SEND;
              end
            end
            default: ;
          endcase
        end
        ST_SEND: begin
          if (!tx_full) begin
            wr_uart = 1'b1;
            if (burst_cnt > 8'd1) begin
              burst_n = burst_cnt - 8'd1;
              tx_n    = tx_reg + 1'b1;
            end else begin
              burst_n = '0;
              state_n = ST_IDLE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Display refresh: top two counter bits pick the digit.
  always_ff @(posedge clk) begin
    if (reset) refresh <= '0;
    else       refresh <= refresh + 1'b1;
  end

  assign digit_sel = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    hex_digit = led[3:0];
    an_n      = 4'b1110;
    case (digit_sel)
      2'd0: begin hex_digit = led[3:0];    an_n = 4'b1110; end
      2'd1: begin hex_digit = led[7:4];    an_n = 4'b1101; end
      2'd2: begin hex_digit = tx_cnt[3:0]; an_n = 4'b1011; end
      2'd3: begin hex_digit = tx_cnt[7:4]; an_n = 4'b0111; end
      default: ;
    endcase
  end

  hex_to_sseg u_hex_to_sseg (
    .hex  (hex_digit),
    .dp   (1'b0),
    .sseg (sseg_n)
  );

  // Reset values match digit 0 showing a cleared led register.
  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= 4'b1110;
      sseg <= 8'hC0;
    end else begin
      an   <= an_n;
      sseg <= sseg_n;
    end
  end

endmodule
